// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: registered execute stage with sticky condition codes.
//
// Accepts one operation per valid/ready handshake, registers the result with
// its destination tag and opcode, and updates the sticky {C, N, Z} flags.
// SHR_MODE selects a single-cycle barrel shifter (0) or an iterative
// one-bit-per-cycle shifter (1).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_op, in_a, in_b   opcode and operands (in_b is the shift amount for SHR)
//   in_tag              destination register index, carried unchanged
//   out_valid/out_ready output handshake
//   out_result, out_tag, out_op  registered result, tag and opcode
//   cc                  sticky condition codes {C, N, Z}
module alu_exec_pipe #(
    parameter int WIDTH    = 16,
    parameter int TAG_W    = 6,
    parameter int SHR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_op,
    output logic [2:0]       cc
);

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ANY = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [TAG_W-1:0]   pend_tag_q, pend_tag_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [3:0]         out_op_q, out_op_d;
    logic [2:0]         cc_q, cc_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   shr_res;
    logic [CNT_W-1:0]   shr_n;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH-1:0]   sh_step;
    logic               out_free;
    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   ld_res;
    logic [TAG_W-1:0]   ld_tag;
    logic [3:0]         ld_op;
    logic               ld_c;
    logic               ld_upd;

    assign sum = {1'b0, in_a} + {1'b0, in_b};

    // SHR keeps the operand MSB in place and shifts only the bits below it,
    // so an oversized amount leaves {a[MSB], zeros}.
    assign sh_step = {sh_q[WIDTH-1], 1'b0, sh_q[WIDTH-2:1]};

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        shr_res            = '0;
        shr_res[WIDTH-1]   = in_a[WIDTH-1];
        shr_n              = CNT_W'(WIDTH);
        if (in_b < WIDTH_V) begin
            shr_res[WIDTH-2:0] = in_a[WIDTH-2:0] >> in_b;
            shr_n              = in_b[CNT_W-1:0];
        end
    end

    always_comb begin
        alu_res = in_a;
        alu_c   = 1'b0;
        case (in_op)
            OP_ADD:  {alu_c, alu_res} = sum;
            OP_AND:  alu_res = in_a & in_b;
            OP_ANY:  alu_res = (in_a != '0) ? WIDTH'(1) : '0;
            OP_OR:   alu_res = in_a | in_b;
            OP_SHR:  alu_res = shr_res;
            OP_XOR:  alu_res = in_a ^ in_b;
            default: alu_res = in_a;
        endcase
    end

    always_comb begin
        out_free     = !out_valid_q || out_ready;
        in_ready     = rst_n && (state_q == IDLE) && out_free;
        accept       = in_valid && in_ready;

        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        pend_tag_d   = pend_tag_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_op_d     = out_op_q;
        cc_d         = cc_q;

        load   = 1'b0;
        ld_res = alu_res;
        ld_tag = in_tag;
        ld_op  = in_op;
        ld_c   = alu_c;
        ld_upd = (in_op >= OP_ADD) && (in_op <= OP_XOR);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((SHR_MODE == 1) && (in_op == OP_SHR) && (shr_n != '0)) begin
                        state_d    = SHIFT;
                        sh_d       = in_a;
                        cnt_d      = shr_n;
                        pend_tag_d = in_tag;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    sh_d  = sh_step;
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // The last shift step feeds the output directly; if the output
                // is still occupied the finished value parks with the count at 0.
                if ((cnt_q <= CNT_W'(1)) && out_free) begin
                    load    = 1'b1;
                    ld_res  = (cnt_q != '0) ? sh_step : sh_q;
                    ld_tag  = pend_tag_q;
                    ld_op   = OP_SHR;
                    ld_c    = 1'b0;
                    ld_upd  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            out_valid_d  = 1'b1;
            out_result_d = ld_res;
            out_tag_d    = ld_tag;
            out_op_d     = ld_op;
            if (ld_upd) begin
                cc_d = {ld_c, ld_res[WIDTH-1], (ld_res == '0)};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_op_q     <= '0;
            cc_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_op_q     <= out_op_d;
            cc_q         <= cc_d;
        end
    end

    // NOTE: the shift register and pending tag are pure datapath, always
    // loaded before they are read, so they carry no reset.
    always_ff @(posedge clk) begin
        sh_q       <= sh_d;
        pend_tag_q <= pend_tag_d;
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_op     = out_op_q;
    assign cc         = cc_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Testbench for alu_exec_pipe: one instance per shifter mode, directed
// vectors with hand-computed results, scoreboard queues checked by a monitor.
module tb_alu_exec_pipe;

    localparam int W  = 16;
    localparam int TW = 6;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic [3:0]    op;
        logic [2:0]    cc;
        int            lat;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    in_op = '0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    int            sel = 0;

    logic          iv0, iv1;
    logic          ir   [2];
    logic          ov   [2];
    logic [W-1:0]  ores [2];
    logic [TW-1:0] otag [2];
    logic [3:0]    oop  [2];
    logic [2:0]    occ  [2];

    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign iv0 = in_valid && (sel == 0);
    assign iv1 = in_valid && (sel == 1);

    alu_exec_pipe #(.WIDTH(W), .TAG_W(TW), .SHR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir[0]),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov[0]), .out_ready(out_ready), .out_result(ores[0]),
        .out_tag(otag[0]), .out_op(oop[0]), .cc(occ[0])
    );

    alu_exec_pipe #(.WIDTH(W), .TAG_W(TW), .SHR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir[1]),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(ov[1]), .out_ready(out_ready), .out_result(ores[1]),
        .out_tag(otag[1]), .out_op(oop[1]), .cc(occ[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            nchk++;
            nfail++;
            $display("FAIL unexpected_output dut%0d: got result %h tag %h, required none", d, ores[d], otag[d]);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("result dut%0d tag%0h", d, e.tag), 32'(ores[d]), 32'(e.res));
        check($sformatf("tag dut%0d tag%0h", d, e.tag), 32'(otag[d]), 32'(e.tag));
        check($sformatf("op dut%0d tag%0h", d, e.tag), 32'(oop[d]), 32'(e.op));
        check($sformatf("cc dut%0d tag%0h", d, e.tag), 32'(occ[d]), 32'(e.cc));
        if (e.lat > 0)
            check($sformatf("latency dut%0d tag%0h", d, e.tag), 32'(cyc - e.acc), 32'(e.lat));
    endtask

    // Monitor: an output transfer happens at the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov[0] && out_ready) mon(0);
            if (ov[1] && out_ready) mon(1);
        end
    end

    // Drive one operation on the selected instance, wait for the accept and
    // push the expectation; lat=0 disables the latency comparison.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag, input logic [W-1:0] res,
                         input logic [2:0] ccv, input int lat, input bit push);
        exp_t e;
        bit   got;
        got      = 1'b0;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ir[sel]) begin
                got   = 1'b1;
                e.res = res;
                e.tag = tag;
                e.op  = op;
                e.cc  = ccv;
                e.lat = lat;
                e.acc = cyc;
                if (push) begin
                    if (sel == 0) q0.push_back(e);
                    else          q1.push_back(e);
                end
            end
        end
        if (!got) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout tag%0h: got no accept, required accept within 100 cycles", tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset with a valid ADD presented: nothing may be accepted.
        sel = 0; in_valid = 1'b1; in_op = 4'd1; in_a = 16'h0001; in_b = 16'h0001; in_tag = 6'h01;
        repeat (2) begin
            @(negedge clk);
            check("reset in_ready dut0", 32'(ir[0]), 0);
            check("reset in_ready dut1", 32'(ir[1]), 0);
            check("reset out_valid dut0", 32'(ov[0]), 0);
            check("reset cc dut0", 32'(occ[0]), 0);
            check("reset cc dut1", 32'(occ[1]), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("post-reset out_valid dut0", 32'(ov[0]), 0);
        check("post-reset out_result dut0", 32'(ores[0]), 0);
        @(posedge clk); #1;

        // Single-cycle shifter instance; back-to-back with out_ready high.
        sel = 0;
        issue(4'd1, 16'hFFFF, 16'h0001, 6'h05, 16'h0000, 3'b101, 1, 1'b1);
        issue(4'd7, 16'h1234, 16'h0000, 6'h06, 16'h1234, 3'b101, 1, 1'b1);
        issue(4'd5, 16'h8004, 16'h0002, 6'h07, 16'h8001, 3'b010, 1, 1'b1);
        issue(4'd5, 16'h8004, 16'h0014, 6'h08, 16'h8000, 3'b010, 1, 1'b1);
        issue(4'hA, 16'hBEEF, 16'h0000, 6'h09, 16'hBEEF, 3'b010, 1, 1'b1);
        issue(4'd3, 16'h0000, 16'h0000, 6'h0A, 16'h0000, 3'b001, 1, 1'b1);
        issue(4'd3, 16'h0010, 16'h0000, 6'h0B, 16'h0001, 3'b000, 1, 1'b1);
        issue(4'd6, 16'h00FF, 16'h0F0F, 6'h0C, 16'h0FF0, 3'b000, 1, 1'b1);
        issue(4'd2, 16'hF0F0, 16'hFF00, 6'h0D, 16'hF000, 3'b010, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: first result must hold, second op must wait.
        out_ready = 1'b0;
        issue(4'd1, 16'h0003, 16'h0004, 6'h01, 16'h0007, 3'b000, 0, 1'b1);
        in_op = 4'd4; in_a = 16'h00F0; in_b = 16'h000F; in_tag = 6'h02; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stall in_ready", 32'(ir[0]), 0);
            check("stall out_valid", 32'(ov[0]), 1);
            check("stall out_result", 32'(ores[0]), 32'h0007);
            check("stall out_tag", 32'(otag[0]), 32'h01);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(4'd4, 16'h00F0, 16'h000F, 6'h02, 16'h00FF, 3'b000, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Iterative shifter instance.
        sel = 1;
        issue(4'd5, 16'h8004, 16'h0002, 6'h10, 16'h8001, 3'b010, 3, 1'b1);
        issue(4'd5, 16'h8004, 16'h0014, 6'h11, 16'h8000, 3'b010, 17, 1'b1);
        issue(4'd1, 16'h0001, 16'h0001, 6'h12, 16'h0002, 3'b000, 1, 1'b1);
        issue(4'd5, 16'h1234, 16'h0000, 6'h13, 16'h1234, 3'b000, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a shift: the SHR must never be emitted.
        issue(4'd5, 16'h8000, 16'h000A, 6'h14, 16'h0000, 3'b000, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midop reset in_ready low", 32'(ir[1]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midop reset out_valid", 32'(ov[1]), 0);
        check("midop reset back to idle", 32'(ir[1]), 1);
        check("midop reset cc", 32'(occ[1]), 0);
        repeat (12) @(posedge clk);
        #1;
        check("midop no late emission", 32'(ov[1]), 0);
        issue(4'd1, 16'h0001, 16'h0001, 6'h15, 16'h0002, 3'b000, 1, 1'b1);

        // Drain and confirm nothing was lost.
        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard empty dut0", 32'(q0.size()), 0);
        check("scoreboard empty dut1", 32'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
